// File: rtl/image_bram_arbiter.sv
// Single-port image BRAM arbiter: the loader fills a frame, then highlight writes and
// output reads share the port. Define ARB_STATS_EN to build the conflict_count statistic.
module image_bram_arbiter #(
    parameter int unsigned IMAGE_SIZE = 921600,
    localparam int unsigned ADDR_W = $clog2(IMAGE_SIZE)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ld_wr_en,
    input  logic [ADDR_W-1:0] ld_wr_addr,
    input  logic [23:0]       ld_wr_data,
    output logic              ld_ready,
    input  logic              hl_wr_req,
    input  logic [ADDR_W-1:0] hl_wr_addr,
    input  logic [23:0]       hl_wr_data,
    output logic              hl_grant,
    input  logic              out_rd_req,
    input  logic [ADDR_W-1:0] out_rd_addr,
    output logic              out_grant,
    output logic              out_rd_valid,
    output logic [23:0]       out_rd_data,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [23:0]       bram_din,
    input  logic [23:0]       bram_dout,
    output logic              frame_done,
    output logic [31:0]       conflict_count
);

    localparam int unsigned      CNT_W    = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IMAGE_SIZE - 1);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StShare,
        StDrain
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] ld_cnt_q, ld_cnt_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic             last_hl_q, last_hl_d;
    logic             rd_valid_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            ld_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            last_hl_q  <= 1'b1;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ld_cnt_q   <= ld_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            last_hl_q  <= last_hl_d;
            rd_valid_q <= out_grant;
        end
    end

    always_comb begin
        state_d    = state_q;
        ld_cnt_d   = ld_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        last_hl_d  = last_hl_q;
        ld_ready   = 1'b0;
        hl_grant   = 1'b0;
        out_grant  = 1'b0;
        bram_en    = 1'b0;
        bram_we    = 1'b0;
        bram_addr  = '0;
        bram_din   = '0;
        frame_done = 1'b0;

        unique case (state_q)
            StIdle, StLoad: begin
                ld_ready = 1'b1;
                if (ld_wr_en) begin
                    bram_en   = 1'b1;
                    bram_we   = 1'b1;
                    bram_addr = ld_wr_addr;
                    bram_din  = ld_wr_data;
                    ld_cnt_d  = ld_cnt_q + CNT_W'(1);
                    state_d   = (ld_cnt_q == LAST_CNT) ? StShare : StLoad;
                end
            end
            StShare: begin
                // On a tie the port that did not win last time gets the BRAM.
                hl_grant  = hl_wr_req & (~out_rd_req | ~last_hl_q);
                out_grant = out_rd_req & (~hl_wr_req | last_hl_q);
                if (hl_grant) begin
                    bram_en   = 1'b1;
                    bram_we   = 1'b1;
                    bram_addr = hl_wr_addr;
                    bram_din  = hl_wr_data;
                    last_hl_d = 1'b1;
                end else if (out_grant) begin
                    bram_en   = 1'b1;
                    bram_addr = out_rd_addr;
                    last_hl_d = 1'b0;
                    rd_cnt_d  = rd_cnt_q + CNT_W'(1);
                    if (rd_cnt_q == LAST_CNT) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                // Final read data returns this cycle; frame_done marks the frame boundary.
                frame_done = 1'b1;
                state_d    = StIdle;
                ld_cnt_d   = '0;
                rd_cnt_d   = '0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // While reset is held the outputs look like an idle arbiter with no BRAM traffic.
        if (reset) begin
            ld_ready   = 1'b1;
            hl_grant   = 1'b0;
            out_grant  = 1'b0;
            bram_en    = 1'b0;
            bram_we    = 1'b0;
            bram_addr  = '0;
            bram_din   = '0;
            frame_done = 1'b0;
        end
    end

    assign out_rd_valid = rd_valid_q;
    assign out_rd_data  = bram_dout;

`ifdef ARB_STATS_EN
    logic [31:0] conflict_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            conflict_q <= '0;
        end else if (state_q == StShare && hl_wr_req && out_rd_req && conflict_q != '1) begin
            conflict_q <= conflict_q + 32'd1;
        end
    end

    assign conflict_count = conflict_q;
`else
    assign conflict_count = '0;
`endif

endmodule

// File: tb/tb_image_bram_arbiter.sv
// Self-checking bench for image_bram_arbiter with IMAGE_SIZE=16, a BRAM model and a
// read-data scoreboard fed on every observed out_grant.
module tb_image_bram_arbiter;

    localparam int unsigned IMAGE_SIZE = 16;
    localparam int unsigned ADDR_W     = $clog2(IMAGE_SIZE);
`ifdef ARB_STATS_EN
    localparam int unsigned EXP_CONFLICTS = 4;
`else
    localparam int unsigned EXP_CONFLICTS = 0;
`endif

    logic              clock = 1'b0;
    logic              reset;
    logic              ld_wr_en;
    logic [ADDR_W-1:0] ld_wr_addr;
    logic [23:0]       ld_wr_data;
    logic              ld_ready;
    logic              hl_wr_req;
    logic [ADDR_W-1:0] hl_wr_addr;
    logic [23:0]       hl_wr_data;
    logic              hl_grant;
    logic              out_rd_req;
    logic [ADDR_W-1:0] out_rd_addr;
    logic              out_grant;
    logic              out_rd_valid;
    logic [23:0]       out_rd_data;
    logic              bram_en;
    logic              bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [23:0]       bram_din;
    logic [23:0]       bram_dout;
    logic              frame_done;
    logic [31:0]       conflict_count;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [23:0] mem     [IMAGE_SIZE];
    logic [23:0] ref_mem [IMAGE_SIZE];
    logic [23:0] sb_q    [$];

    always #5 clock = ~clock;

    image_bram_arbiter #(
        .IMAGE_SIZE(IMAGE_SIZE)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .ld_wr_en       (ld_wr_en),
        .ld_wr_addr     (ld_wr_addr),
        .ld_wr_data     (ld_wr_data),
        .ld_ready       (ld_ready),
        .hl_wr_req      (hl_wr_req),
        .hl_wr_addr     (hl_wr_addr),
        .hl_wr_data     (hl_wr_data),
        .hl_grant       (hl_grant),
        .out_rd_req     (out_rd_req),
        .out_rd_addr    (out_rd_addr),
        .out_grant      (out_grant),
        .out_rd_valid   (out_rd_valid),
        .out_rd_data    (out_rd_data),
        .bram_en        (bram_en),
        .bram_we        (bram_we),
        .bram_addr      (bram_addr),
        .bram_din       (bram_din),
        .bram_dout      (bram_dout),
        .frame_done     (frame_done),
        .conflict_count (conflict_count)
    );

    // Single-port BRAM, one-cycle read latency.
    always @(posedge clock) begin
        if (bram_en) begin
            if (bram_we) mem[bram_addr] <= bram_din;
            else         bram_dout <= mem[bram_addr];
        end
    end

    // Scoreboard: pop on returned data, push the expected pixel on each read grant.
    always @(negedge clock) begin
        logic [23:0] exp_data;
        #2;
        if (out_rd_valid === 1'b1) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_errors++;
                $display("FAIL sb_unexpected_valid: got valid data %h, want no pending read",
                         out_rd_data);
            end else begin
                exp_data = sb_q.pop_front();
                if (out_rd_data !== exp_data) begin
                    n_errors++;
                    $display("FAIL sb_read_data: got %h want %h", out_rd_data, exp_data);
                end
            end
        end
        if (out_grant === 1'b1) sb_q.push_back(ref_mem[out_rd_addr]);
    end

    function automatic logic [23:0] pix(int frame, int i);
        return 24'(frame * 24'h100000 + i * 24'h010203 + 24'h000011);
    endfunction

    task automatic test_reset();
        @(negedge clock);
        reset = 1'b1; ld_wr_en = 1'b1; hl_wr_req = 1'b1; out_rd_req = 1'b1;
        @(negedge clock); #1;
        n_checks++;
        if (ld_ready !== 1'b1) begin
            n_errors++; $display("FAIL reset_ld_ready: got %b want 1", ld_ready);
        end
        n_checks++;
        if ({hl_grant, out_grant} !== 2'b00) begin
            n_errors++; $display("FAIL reset_grants: got %b want 00", {hl_grant, out_grant});
        end
        n_checks++;
        if (bram_en !== 1'b0) begin
            n_errors++; $display("FAIL reset_bram_en: got %b want 0", bram_en);
        end
        n_checks++;
        if ({out_rd_valid, frame_done} !== 2'b00) begin
            n_errors++;
            $display("FAIL reset_valid_done: got %b want 00", {out_rd_valid, frame_done});
        end
        n_checks++;
        if (conflict_count !== 32'd0) begin
            n_errors++; $display("FAIL reset_conflicts: got %0d want 0", conflict_count);
        end
        @(negedge clock);
        reset = 1'b0; ld_wr_en = 1'b0; hl_wr_req = 1'b0; out_rd_req = 1'b0;
    endtask

    // Loader writes; stray highlight/read requests must not be granted while loading.
    task automatic test_load(int frame, int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            ld_wr_en = 1'b1; ld_wr_addr = ADDR_W'(i); ld_wr_data = pix(frame, i);
            out_rd_req = i[0]; hl_wr_req = i[1];
            #1;
            n_checks++;
            if ({ld_ready, bram_en, bram_we} !== 3'b111) begin
                n_errors++;
                $display("FAIL load_ctrl[%0d]: got ready/en/we=%b want 111", i,
                         {ld_ready, bram_en, bram_we});
            end
            n_checks++;
            if (bram_addr !== ADDR_W'(i) || bram_din !== pix(frame, i)) begin
                n_errors++;
                $display("FAIL load_addr_data[%0d]: got %0d/%h want %0d/%h", i, bram_addr,
                         bram_din, i, pix(frame, i));
            end
            n_checks++;
            if ({hl_grant, out_grant} !== 2'b00) begin
                n_errors++;
                $display("FAIL load_no_grant[%0d]: got %b want 00", i, {hl_grant, out_grant});
            end
            ref_mem[i] = pix(frame, i);
        end
        @(negedge clock);
        ld_wr_en = 1'b0; out_rd_req = 1'b0; hl_wr_req = 1'b0;
    endtask

    task automatic test_load_ignored();
        ld_wr_en = 1'b1; ld_wr_addr = ADDR_W'(3); ld_wr_data = 24'hDEAD00;
        #1;
        n_checks++;
        if (ld_ready !== 1'b0) begin
            n_errors++; $display("FAIL share_ld_ready: got %b want 0", ld_ready);
        end
        n_checks++;
        if ({bram_en, bram_we} !== 2'b00) begin
            n_errors++; $display("FAIL share_ignore_ld: got en/we=%b want 00", {bram_en, bram_we});
        end
        @(negedge clock);
        ld_wr_en = 1'b0;
    endtask

    task automatic test_contention();
        int ri = 0;
        int hi = 0;
        logic exp_out;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            hl_wr_req = 1'b1; hl_wr_addr = ADDR_W'(8 + hi); hl_wr_data = pix(7, 8 + hi);
            out_rd_req = 1'b1; out_rd_addr = ADDR_W'(ri);
            #1;
            exp_out = (c % 2 == 0);
            n_checks++;
            if ({out_grant, hl_grant} !== {exp_out, ~exp_out}) begin
                n_errors++;
                $display("FAIL contention_grant[%0d]: got out/hl=%b want %b", c,
                         {out_grant, hl_grant}, {exp_out, ~exp_out});
            end
            n_checks++;
            if ({bram_en, bram_we} !== {1'b1, ~exp_out} ||
                bram_addr !== (exp_out ? ADDR_W'(ri) : ADDR_W'(8 + hi))) begin
                n_errors++;
                $display("FAIL contention_bram[%0d]: got en/we=%b addr=%0d", c,
                         {bram_en, bram_we}, bram_addr);
            end
            if (exp_out) ri++;
            else begin
                ref_mem[8 + hi] = pix(7, 8 + hi);
                hi++;
            end
        end
        @(negedge clock);
        hl_wr_req = 1'b0; out_rd_req = 1'b0;
        #1;
        n_checks++;
        if (conflict_count !== 32'(EXP_CONFLICTS)) begin
            n_errors++;
            $display("FAIL contention_count: got %0d want %0d", conflict_count, EXP_CONFLICTS);
        end
        n_checks++;
        if (out_rd_valid !== 1'b0) begin
            n_errors++; $display("FAIL valid_after_hl: got %b want 0", out_rd_valid);
        end
    endtask

    task automatic test_lone_hl();
        @(negedge clock);
        hl_wr_req = 1'b1; hl_wr_addr = ADDR_W'(12); hl_wr_data = pix(7, 12);
        #1;
        n_checks++;
        if ({hl_grant, out_grant, bram_we} !== 3'b101 || bram_din !== pix(7, 12)) begin
            n_errors++;
            $display("FAIL lone_hl: got hl/out/we=%b din=%h want 101 %h",
                     {hl_grant, out_grant, bram_we}, bram_din, pix(7, 12));
        end
        ref_mem[12] = pix(7, 12);
        @(negedge clock);
        hl_wr_req = 1'b0;
    endtask

    // Tie after a highlight grant goes to the read; its data returns one cycle later.
    task automatic test_read_latency();
        @(negedge clock);
        out_rd_req = 1'b1; out_rd_addr = ADDR_W'(5);
        hl_wr_req = 1'b1; hl_wr_addr = ADDR_W'(13); hl_wr_data = pix(7, 13);
        #1;
        n_checks++;
        if ({out_grant, hl_grant, bram_we} !== 3'b100 || bram_addr !== ADDR_W'(5)) begin
            n_errors++;
            $display("FAIL latency_grant: got out/hl/we=%b addr=%0d want 100 5",
                     {out_grant, hl_grant, bram_we}, bram_addr);
        end
        @(negedge clock);
        out_rd_req = 1'b0;
        #1;
        n_checks++;
        if (out_rd_valid !== 1'b1 || out_rd_data !== ref_mem[5]) begin
            n_errors++;
            $display("FAIL latency_data: got valid=%b data=%h want 1 %h", out_rd_valid,
                     out_rd_data, ref_mem[5]);
        end
        n_checks++;
        if (hl_grant !== 1'b1) begin
            n_errors++; $display("FAIL held_hl_grant: got %b want 1", hl_grant);
        end
        ref_mem[13] = pix(7, 13);
        @(negedge clock);
        hl_wr_req = 1'b0;
    endtask

    task automatic test_frame_end(int start);
        for (int k = start; k < IMAGE_SIZE; k++) begin
            @(negedge clock);
            out_rd_req = 1'b1; out_rd_addr = ADDR_W'(k);
            #1;
            n_checks++;
            if ({out_grant, bram_en, bram_we} !== 3'b110 || bram_addr !== ADDR_W'(k)) begin
                n_errors++;
                $display("FAIL frame_read[%0d]: got grant/en/we=%b addr=%0d", k,
                         {out_grant, bram_en, bram_we}, bram_addr);
            end
        end
        @(negedge clock);
        hl_wr_req = 1'b1;
        #1;
        n_checks++;
        if ({frame_done, out_rd_valid} !== 2'b11) begin
            n_errors++;
            $display("FAIL drain_done_valid: got %b want 11", {frame_done, out_rd_valid});
        end
        n_checks++;
        if ({hl_grant, out_grant, bram_en} !== 3'b000) begin
            n_errors++;
            $display("FAIL drain_no_grant: got hl/out/en=%b want 000",
                     {hl_grant, out_grant, bram_en});
        end
        @(negedge clock);
        #1;
        n_checks++;
        if ({frame_done, ld_ready, hl_grant, out_grant} !== 4'b0100) begin
            n_errors++;
            $display("FAIL idle_after_frame: got done/ready/hl/out=%b want 0100",
                     {frame_done, ld_ready, hl_grant, out_grant});
        end
        hl_wr_req = 1'b0; out_rd_req = 1'b0;
        @(negedge clock); #3;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++; $display("FAIL sb_drained: got %0d pending want 0", sb_q.size());
        end
    endtask

    task automatic test_reset_midframe();
        test_load(1, 7);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        n_checks++;
        if ({ld_ready, out_rd_valid, bram_en} !== 3'b100) begin
            n_errors++;
            $display("FAIL midframe_reset: got ready/valid/en=%b want 100",
                     {ld_ready, out_rd_valid, bram_en});
        end
    endtask

    task automatic test_back_to_back();
        test_load(2, IMAGE_SIZE);
        test_load_ignored();
        test_frame_end(0);
    endtask

    initial begin
        reset = 1'b1; ld_wr_en = 1'b0; ld_wr_addr = '0; ld_wr_data = '0;
        hl_wr_req = 1'b0; hl_wr_addr = '0; hl_wr_data = '0;
        out_rd_req = 1'b0; out_rd_addr = '0;
        test_reset();
        test_load(0, IMAGE_SIZE);
        test_load_ignored();
        test_contention();
        test_lone_hl();
        test_read_latency();
        test_frame_end(3);
        test_reset_midframe();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/image_bram_arbiter.md
IMAGE_BRAM_ARBITER -- requirements
Module: image_bram_arbiter

Interface
REQ-001 SHALL have parameter IMAGE_SIZE, default 921600 (1280 x 720), pixels per frame; ADDR_W = $clog2(IMAGE_SIZE) is derived.
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 SHALL have port clock  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  synchronous active-high reset.
REQ-005 SHALL have ports ld_wr_en  input  1 / ld_wr_addr  input  ADDR_W / ld_wr_data  input  24 / ld_ready  output  1: image loader write port.
REQ-006 SHALL have ports hl_wr_req  input  1 / hl_wr_addr  input  ADDR_W / hl_wr_data  input  24 / hl_grant  output  1: lane-highlight write port.
REQ-007 SHALL have ports out_rd_req  input  1 / out_rd_addr  input  ADDR_W / out_grant  output  1 / out_rd_valid  output  1 / out_rd_data  output  24: final-image read port.
REQ-008 SHALL have ports bram_en  output  1 / bram_we  output  1 / bram_addr  output  ADDR_W / bram_din  output  24 / bram_dout  input  24: single-port image BRAM with 1-cycle read latency.
REQ-009 SHALL have ports frame_done  output  1  one-cycle end-of-frame pulse, and conflict_count  output  32  contention statistic.

Function
REQ-010 SHALL implement FSM states IDLE, LOAD, SHARE, DRAIN.
REQ-011 IDLE: ld_ready=1; an ld_wr_en is accepted, issued to BRAM, counts as pixel 0, and moves FSM to LOAD.
REQ-012 LOAD: ld_ready=1, hl_grant=0, out_grant=0; each ld_wr_en increments load count; the write taking the count to IMAGE_SIZE moves FSM to SHARE next cycle.
REQ-013 SHARE: ld_ready=0; ld_wr_en ignored (no BRAM access).
REQ-014 SHARE: exactly one of hl/out granted per cycle when requested; a lone requester is granted; on simultaneous requests grant goes to the requester not granted last (last_grant bit, updated only on a grant).
REQ-015 Grants SHALL be combinational from same-cycle requests; a requester holds request/address/data until it sees its grant.
REQ-016 Granted write: bram_en=1, bram_we=1, bram_addr/bram_din from that port; granted read: bram_en=1, bram_we=0, bram_addr=out_rd_addr; no grant: bram_en=0, bram_we=0.
REQ-017 out_rd_valid SHALL be a registered copy of out_grant (1-cycle latency); out_rd_data SHALL pass bram_dout through unregistered.
REQ-018 SHARE: each out_grant increments read count; the grant taking it to IMAGE_SIZE moves FSM to DRAIN.
REQ-019 DRAIN: no grants; lasts one cycle (final out_rd_valid); then frame_done=1 for that cycle and FSM enters IDLE.
REQ-020 Load/read counters SHALL be ADDR_W+1 bits, cleared on IDLE entry; no wrap within a frame.
REQ-021 Addresses SHALL be passed unmodified; no range checking.

Reset
REQ-022 On reset: FSM=IDLE, counters=0, last_grant=highlight (first tie goes to read), out_rd_valid=0, frame_done=0, conflict_count=0.
REQ-023 Reset asserted mid-frame SHALL abort the frame at the next edge; no pending read returns valid afterwards.
REQ-024 Outputs in reset cycle follow IDLE decode: ld_ready=1, grants 0, bram_en=0.

Configuration
REQ-025 With macro ARB_STATS_EN defined, conflict_count SHALL increment (saturating at 2^32-1) each SHARE cycle with hl_wr_req and out_rd_req both high, cleared only by reset.
REQ-026 Without ARB_STATS_EN, conflict_count SHALL be constant 0 and no counter logic synthesized.

Verification (IMAGE_SIZE=16)
REQ-027 Load: 16 consecutive ld_wr_en to addr 0..15 -> 16 BRAM writes, bram_we=1, FSM=SHARE after 16th; extra ld_wr_en then ignored, ld_ready=0.
REQ-028 Contention: hl and out both held high in SHARE -> grants alternate out,hl,out,hl; conflict_count=4 after 4 cycles (ARB_STATS_EN).
REQ-029 Read latency: out_rd_addr=5 granted cycle N -> out_rd_valid=1 cycle N+1, out_rd_data=pixel written at 5.
REQ-030 Frame end: 16th read grant -> DRAIN, frame_done pulse next cycle, FSM IDLE, ld_ready=1.
REQ-031 Reset after 7 loaded pixels -> IDLE, load count 0; next 16 writes complete a normal frame.
REQ-032 Build without ARB_STATS_EN, REQ-028 stimulus -> same grants, conflict_count=0.
